// File: rtl/wnd_col_reader_if.sv
// -----------------------------------------------------------------------------
// wnd_col_reader_if
// Bundles the two buses of the column reader:
//   - BRAM read port : bram_rd_en / bram_rd_addr (to BRAM), bram_rd_data (from BRAM)
//   - column stream  : col_data / col_valid / col_x / col_last (to consumer),
//                      col_ready (from consumer)
// modport master : the column reader side
// modport slave  : the BRAM + downstream consumer side
// -----------------------------------------------------------------------------
interface wnd_col_reader_if #(
  parameter int NLINES = 8
);
  logic                  bram_rd_en;
  logic [12:0]           bram_rd_addr;
  logic [15:0]           bram_rd_data;
  logic [8*NLINES-1:0]   col_data;
  logic                  col_valid;
  logic                  col_ready;
  logic [9:0]            col_x;
  logic                  col_last;

  modport master (
    output bram_rd_en, bram_rd_addr, col_data, col_valid, col_x, col_last,
    input  bram_rd_data, col_ready
  );

  modport slave (
    input  bram_rd_en, bram_rd_addr, col_data, col_valid, col_x, col_last,
    output bram_rd_data, col_ready
  );
endinterface

// File: rtl/wnd_col_reader.sv
// -----------------------------------------------------------------------------
// wnd_col_reader
// Sweeps a circular NLINES x HRES grey-pixel BRAM window column by column and
// hands out one NLINES-tall pixel column per valid/ready handshake. After each
// full row sweep (except the last of a frame) it pulses o_pixel_ack so the
// writer can refill the oldest line, then waits for HRES writer strobes.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_wnd_in_bram    writer flag: window full (sampled in IDLE / FRAME_END)
//   i_pxconv_wr_en   writer strobe, one pixel per high cycle
//   col_if           master side of the BRAM read port + column stream
//   o_pixel_ack      one-cycle pulse: one line slot free
//   o_frame_done     one-cycle pulse after the last sweep of a frame
//   o_busy           high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module wnd_col_reader #(
  parameter int HRES   = 640,
  parameter int VRES   = 480,
  parameter int NLINES = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wnd_in_bram,
  input  logic             i_pxconv_wr_en,
  wnd_col_reader_if.master col_if,
  output logic             o_pixel_ack,
  output logic             o_frame_done,
  output logic             o_busy
);
  localparam int KW = $clog2(NLINES + 1);

  localparam logic [12:0]   C_HRES       = 13'(HRES);
  localparam logic [12:0]   C_DEPTH      = 13'(NLINES * HRES);
  localparam logic [9:0]    C_XLAST      = 10'(HRES - 1);
  localparam logic [9:0]    C_WR_FULL    = 10'(HRES);
  localparam logic [8:0]    C_LAST_SWEEP = 9'(VRES - NLINES);
  localparam logic [KW-1:0] C_K_LAST_RD  = KW'(NLINES - 1);
  localparam logic [KW-1:0] C_K_DONE     = KW'(NLINES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
    S_ACK,
    S_WAIT_LINE,
    S_FRAME_END
  } state_t;

  state_t      r_state;
  logic [9:0]  r_x;
  logic [8:0]  r_sweep_cnt;
  logic [12:0] r_top_base;   // base of the oldest row, multiple of HRES
  logic [12:0] r_row_base;   // base of the row whose address is on the bus
  logic [KW-1:0] r_k;        // cycles spent in the current READ
  logic [9:0]  r_wr_cnt;
  logic        r_bram_rd_en;
  logic [12:0] r_bram_rd_addr;
  logic        r_col_valid;
  logic [9:0]  r_col_x;
  logic        r_col_last;
  logic        r_pixel_ack;
  logic        r_frame_done;
  logic [7:0]  r_lane [NLINES];

  logic [12:0] w_x_ext;
  logic [12:0] w_row_sum;
  logic [12:0] w_next_row_base;
  logic [12:0] w_top_sum;
  logic [12:0] w_next_top;
  logic [9:0]  w_wr_cnt_next;
  logic        w_unused_hi;

  assign w_x_ext = {3'b000, r_x};

  // Row stepping without a multiplier: add HRES, fold back at the buffer end.
  assign w_row_sum       = r_row_base + C_HRES;
  assign w_next_row_base = (w_row_sum >= C_DEPTH) ? (w_row_sum - C_DEPTH) : w_row_sum;
  assign w_top_sum       = r_top_base + C_HRES;
  assign w_next_top      = (w_top_sum >= C_DEPTH) ? (w_top_sum - C_DEPTH) : w_top_sum;

  // Writer strobe counter saturates at HRES; surplus strobes are dropped.
  assign w_wr_cnt_next = (i_pxconv_wr_en && (r_wr_cnt != C_WR_FULL)) ? (r_wr_cnt + 10'd1) : r_wr_cnt;

  // Only the grey byte is used; the upper byte is deliberately ignored.
  assign w_unused_hi = ^col_if.bram_rd_data[15:8];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_x            <= '0;
      r_sweep_cnt    <= '0;
      r_top_base     <= '0;
      r_row_base     <= '0;
      r_k            <= '0;
      r_wr_cnt       <= '0;
      r_bram_rd_en   <= 1'b0;
      r_bram_rd_addr <= '0;
      r_col_valid    <= 1'b0;
      r_col_x        <= '0;
      r_col_last     <= 1'b0;
      r_pixel_ack    <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_wnd_in_bram) begin
            // First read is presented in the very first READ cycle.
            r_x            <= '0;
            r_sweep_cnt    <= '0;
            r_top_base     <= '0;
            r_row_base     <= '0;
            r_bram_rd_addr <= '0;
            r_bram_rd_en   <= 1'b1;
            r_k            <= '0;
            r_state        <= S_READ;
          end
        end

        S_READ: begin
          // Cycle k presents row k; lane k-1 is captured by the lane registers.
          r_k <= r_k + 1'b1;
          if (r_k < C_K_LAST_RD) begin
            r_row_base     <= w_next_row_base;
            r_bram_rd_addr <= w_next_row_base + w_x_ext;
          end else begin
            r_bram_rd_en <= 1'b0;
          end
          if (r_k == C_K_DONE) begin
            r_col_valid <= 1'b1;
            r_col_x     <= r_x;
            r_col_last  <= (r_x == C_XLAST);
            r_state     <= S_HOLD;
          end
        end

        S_HOLD: begin
          // col_valid is always high here, so col_ready alone marks the handshake.
          if (col_if.col_ready) begin
            r_col_valid <= 1'b0;
            if (r_x != C_XLAST) begin
              r_x            <= r_x + 10'd1;
              r_k            <= '0;
              r_row_base     <= r_top_base;
              r_bram_rd_addr <= r_top_base + w_x_ext + 13'd1;
              r_bram_rd_en   <= 1'b1;
              r_state        <= S_READ;
            end else begin
              r_x         <= '0;
              r_sweep_cnt <= r_sweep_cnt + 9'd1;
              if (r_sweep_cnt == C_LAST_SWEEP) begin
                r_frame_done <= 1'b1;
                r_state      <= S_FRAME_END;
              end else begin
                r_pixel_ack <= 1'b1;
                r_state     <= S_ACK;
              end
            end
          end
        end

        S_ACK: begin
          r_pixel_ack <= 1'b0;
          r_top_base  <= w_next_top;
          // A writer strobe coinciding with the ack already counts.
          r_wr_cnt    <= i_pxconv_wr_en ? 10'd1 : 10'd0;
          r_state     <= S_WAIT_LINE;
        end

        S_WAIT_LINE: begin
          r_wr_cnt <= w_wr_cnt_next;
          if (w_wr_cnt_next == C_WR_FULL) begin
            // x is already 0, so the first address is just the new top base.
            r_k            <= '0;
            r_row_base     <= r_top_base;
            r_bram_rd_addr <= r_top_base;
            r_bram_rd_en   <= 1'b1;
            r_state        <= S_READ;
          end
        end

        S_FRAME_END: begin
          r_frame_done <= 1'b0;
          if (!i_wnd_in_bram) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Lane gi is filled one cycle after row gi was addressed (1-cycle BRAM).
  genvar gi;
  generate
    for (gi = 0; gi < NLINES; gi++) begin : g_lane
      localparam logic [KW-1:0] C_CAP_K = KW'(gi + 1);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_lane[gi] <= '0;
        end else if ((r_state == S_READ) && (r_k == C_CAP_K)) begin
          r_lane[gi] <= col_if.bram_rd_data[7:0];
        end
      end

      assign col_if.col_data[8*gi +: 8] = r_lane[gi];
    end
  endgenerate

  assign col_if.bram_rd_en   = r_bram_rd_en;
  assign col_if.bram_rd_addr = r_bram_rd_addr;
  assign col_if.col_valid    = r_col_valid;
  assign col_if.col_x        = r_col_x;
  assign col_if.col_last     = r_col_last;
  assign o_pixel_ack         = r_pixel_ack;
  assign o_frame_done        = r_frame_done;
  // Pure decode of the state register, so still glitch-free and input-independent.
  assign o_busy              = (r_state != S_IDLE);
endmodule

// File: tb/tb_wnd_col_reader.sv
`timescale 1ns/1ps
module tb_wnd_col_reader;
  localparam int HRES   = 8;
  localparam int NLINES = 4;
  localparam int VRES   = 6;
  localparam int VRES2  = 12;
  localparam int DEPTH  = NLINES * HRES;
  localparam int NS1    = VRES - NLINES + 1;
  localparam int NS2    = VRES2 - NLINES + 1;

  typedef struct {
    int          sweep;
    int          x;
    logic [31:0] data;
    logic        last;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          x;
    logic        last;
  } col_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- DUT 1: VRES=6 (hand sequences + table) ----------------
  logic wnd1 = 1'b0, wr1 = 1'b0, ack1, fd1, busy1;
  wnd_col_reader_if #(.NLINES(NLINES)) bus1();
  wnd_col_reader #(.HRES(HRES), .VRES(VRES), .NLINES(NLINES)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wnd_in_bram(wnd1), .i_pxconv_wr_en(wr1),
    .col_if(bus1), .o_pixel_ack(ack1), .o_frame_done(fd1), .o_busy(busy1)
  );

  // ---------------- DUT 2: VRES=12 (random, top_base wraps) ----------------
  logic wnd2 = 1'b0, wr2 = 1'b0, ack2, fd2, busy2;
  wnd_col_reader_if #(.NLINES(NLINES)) bus2();
  wnd_col_reader #(.HRES(HRES), .VRES(VRES2), .NLINES(NLINES)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wnd_in_bram(wnd2), .i_pxconv_wr_en(wr2),
    .col_if(bus2), .o_pixel_ack(ack2), .o_frame_done(fd2), .o_busy(busy2)
  );

  // 1-cycle latency BRAM models
  logic [15:0] mem1 [DEPTH];
  logic [15:0] mem2 [DEPTH];
  always @(posedge clk) if (bus1.bram_rd_en) bus1.bram_rd_data <= mem1[bus1.bram_rd_addr[4:0]];
  always @(posedge clk) if (bus2.bram_rd_en) bus2.bram_rd_data <= mem2[bus2.bram_rd_addr[4:0]];

  // ---------------- monitor DUT 1 ----------------
  logic [31:0] hs1_data [64];
  int          hs1_x    [64];
  logic        hs1_last [64];
  int unsigned hs1_cyc  [64];
  int          hs1_n = 0;
  int unsigned ack1_cyc [$];
  int          fd1_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus1.col_valid && bus1.col_ready && hs1_n < 64) begin
        hs1_data[hs1_n] = bus1.col_data;
        hs1_x[hs1_n]    = int'(bus1.col_x);
        hs1_last[hs1_n] = bus1.col_last;
        hs1_cyc[hs1_n]  = cyc;
        $display("dut1 col #%0d x=%0d last=%0d data=0x%08h cyc=%0d",
                 hs1_n, bus1.col_x, bus1.col_last, bus1.col_data, cyc);
        hs1_n++;
      end
      if (ack1) ack1_cyc.push_back(cyc);
      if (fd1) fd1_cnt++;
    end
  end

  // ---------------- monitor DUT 2 ----------------
  col_t        obs2 [$];
  int          ack2_cnt = 0;
  int          fd2_cnt = 0;
  logic        prev_valid2 = 1'b0, prev_hs2 = 1'b0;
  logic [31:0] prev_data2;
  logic [9:0]  prev_x2;

  always @(negedge clk) begin
    col_t c;
    if (rst_n) begin
      if (prev_valid2 && !prev_hs2) begin
        check("dut2_valid_held", bus2.col_valid, 1'b1);
        check("dut2_data_stable", bus2.col_data, prev_data2);
        check("dut2_x_stable", bus2.col_x, prev_x2);
      end
      if (bus2.col_valid) check("dut2_no_read_in_hold", bus2.bram_rd_en, 1'b0);
      if (bus2.col_valid && bus2.col_ready) begin
        c.data = bus2.col_data;
        c.x    = int'(bus2.col_x);
        c.last = bus2.col_last;
        obs2.push_back(c);
      end
      if (ack2) ack2_cnt++;
      if (fd2) fd2_cnt++;
      prev_valid2 = bus2.col_valid;
      prev_hs2    = bus2.col_valid && bus2.col_ready;
      prev_data2  = bus2.col_data;
      prev_x2     = bus2.col_x;
    end
  end

  logic rnd2 = 1'b0;
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd2) begin
      bus2.col_ready = ($urandom_range(0, 3) != 0);
      wr2            = ($urandom_range(0, 1) != 0);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [8];
    col_t        exp_q [$];
    col_t        ce;
    int          guard;
    logic [31:0] d0;

    tbl[0] = '{0, 0, 32'h18100800, 1'b0};
    tbl[1] = '{0, 3, 32'h1B130B03, 1'b0};
    tbl[2] = '{0, 7, 32'h1F170F07, 1'b1};
    tbl[3] = '{1, 0, 32'h00181008, 1'b0};
    tbl[4] = '{1, 3, 32'h031B130B, 1'b0};
    tbl[5] = '{1, 7, 32'h071F170F, 1'b1};
    tbl[6] = '{2, 3, 32'h0B031B13, 1'b0};
    tbl[7] = '{2, 7, 32'h0F071F17, 1'b1};

    for (int a = 0; a < DEPTH; a++) mem1[a] = {8'($urandom), 8'(a)};
    bus1.col_ready    = 1'b1;
    bus2.col_ready    = 1'b0;
    bus1.bram_rd_data = '0;
    bus2.bram_rd_data = '0;

    // ---- reset state ----
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_rd_en", bus1.bram_rd_en, 1'b0);
    check("rst_rd_addr", bus1.bram_rd_addr, 13'd0);
    check("rst_col_data", bus1.col_data, 32'd0);
    check("rst_col_valid", bus1.col_valid, 1'b0);
    check("rst_col_x", bus1.col_x, 10'd0);
    check("rst_col_last", bus1.col_last, 1'b0);
    check("rst_pixel_ack", ack1, 1'b0);
    check("rst_frame_done", fd1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_busy_no_wnd", busy1, 1'b0);

    // ---- first column latency and read order ----
    wnd1 = 1'b1;
    tick();
    check("c0_rd_en", bus1.bram_rd_en, 1'b1);
    check("c0_addr_k0", bus1.bram_rd_addr, 13'd0);
    tick(); check("c0_addr_k1", bus1.bram_rd_addr, 13'd8);
    tick(); check("c0_addr_k2", bus1.bram_rd_addr, 13'd16);
    tick(); check("c0_addr_k3", bus1.bram_rd_addr, 13'd24);
    tick();
    check("c0_rd_done", bus1.bram_rd_en, 1'b0);
    check("c0_valid_early", bus1.col_valid, 1'b0);
    tick();
    check("c0_valid", bus1.col_valid, 1'b1);
    check("c0_busy", busy1, 1'b1);

    // ---- first ack, line wait ----
    guard = 0;
    while (ack1 !== 1'b1 && guard < 200) begin tick(); guard++; end
    check("ack1_timeout", ack1, 1'b1);
    tick();
    for (int i = 0; i < 7; i++) begin
      wr1 = 1'b1; tick();
      wr1 = 1'b0; tick();
      check("wait_no_read", bus1.bram_rd_en, 1'b0);
    end
    wr1 = 1'b1; tick(); wr1 = 1'b0;
    check("s1_rd_en", bus1.bram_rd_en, 1'b1);
    check("s1_addr_k0", bus1.bram_rd_addr, 13'd8);
    tick(); check("s1_addr_k1", bus1.bram_rd_addr, 13'd16);
    tick(); check("s1_addr_k2", bus1.bram_rd_addr, 13'd24);
    tick(); check("s1_addr_k3", bus1.bram_rd_addr, 13'd0);

    // ---- backpressure on x=3 of sweep 1 ----
    guard = 0;
    while (!(bus1.col_valid === 1'b1 && bus1.col_x == 10'd2) && guard < 100) begin tick(); guard++; end
    check("bp_x2_timeout", bus1.col_valid, 1'b1);
    tick();
    bus1.col_ready = 1'b0;
    guard = 0;
    while (bus1.col_valid !== 1'b1 && guard < 50) begin tick(); guard++; end
    check("bp_x3_timeout", bus1.col_valid, 1'b1);
    d0 = bus1.col_data;
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", bus1.col_valid, 1'b1);
      check("bp_col_x", bus1.col_x, 10'd3);
      check("bp_data", bus1.col_data, d0);
      check("bp_no_read", bus1.bram_rd_en, 1'b0);
      tick();
    end
    bus1.col_ready = 1'b1;
    tick();
    check("bp_next_rd_en", bus1.bram_rd_en, 1'b1);
    check("bp_next_addr", bus1.bram_rd_addr, 13'd12);

    // ---- second ack, refill, frame end ----
    guard = 0;
    while (ack1 !== 1'b1 && guard < 300) begin tick(); guard++; end
    check("ack2_timeout", ack1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      wr1 = 1'b1; tick();
      wr1 = 1'b0; tick();
    end
    guard = 0;
    while (fd1 !== 1'b1 && guard < 300) begin tick(); guard++; end
    check("fd_timeout", fd1, 1'b1);
    check("fd_busy", busy1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fe_busy_hold", busy1, 1'b1);
      check("fe_fd_pulse", fd1, 1'b0);
    end
    wnd1 = 1'b0;
    tick();
    check("fe_idle", busy1, 1'b0);
    check("fd_count", fd1_cnt, 1);
    check("ack_count", ack1_cyc.size(), 2);
    check("hs_count", hs1_n, NS1 * HRES);

    // ---- table of column contents ----
    foreach (tbl[i]) begin
      int idx;
      idx = tbl[i].sweep * HRES + tbl[i].x;
      check($sformatf("tbl%0d_data", i), hs1_data[idx], tbl[i].data);
      check($sformatf("tbl%0d_x", i), hs1_x[idx], tbl[i].x);
      check($sformatf("tbl%0d_last", i), hs1_last[idx], tbl[i].last);
    end
    for (int x = 0; x < HRES - 1; x++)
      check("col_period", hs1_cyc[x + 1] - hs1_cyc[x], 6);
    if (ack1_cyc.size() == 2) begin
      check("ack0_timing", ack1_cyc[0], hs1_cyc[HRES - 1] + 1);
      check("ack1_timing", ack1_cyc[1], hs1_cyc[2 * HRES - 1] + 1);
    end

    // ---- reset mid-HOLD ----
    bus1.col_ready = 1'b0;
    wnd1 = 1'b1;
    guard = 0;
    while (bus1.col_valid !== 1'b1 && guard < 50) begin tick(); guard++; end
    check("rh_valid_timeout", bus1.col_valid, 1'b1);
    wnd1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rh_valid", bus1.col_valid, 1'b0);
    check("rh_data", bus1.col_data, 32'd0);
    check("rh_busy", busy1, 1'b0);
    check("rh_rd_en", bus1.bram_rd_en, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rh_idle_busy", busy1, 1'b0);
      check("rh_idle_rd", bus1.bram_rd_en, 1'b0);
    end
    wnd1 = 1'b1;
    tick();
    check("rh_restart_rd", bus1.bram_rd_en, 1'b1);
    check("rh_restart_addr", bus1.bram_rd_addr, 13'd0);
    wnd1 = 1'b0;

    // ---- randomized frames on DUT 2 against a reference model ----
    for (int f = 0; f < 2; f++) begin
      for (int a = 0; a < DEPTH; a++) mem2[a] = 16'($urandom);
      exp_q.delete();
      for (int s = 0; s < NS2; s++) begin
        for (int x = 0; x < HRES; x++) begin
          ce.data = '0;
          for (int k = 0; k < NLINES; k++)
            ce.data[8 * k +: 8] = mem2[((s + k) * HRES) % DEPTH + x][7:0];
          ce.x    = x;
          ce.last = (x == HRES - 1);
          exp_q.push_back(ce);
        end
      end
      obs2.delete();
      ack2_cnt = 0;
      fd2_cnt  = 0;
      wnd2 = 1'b1;
      rnd2 = 1'b1;
      guard = 0;
      while (fd2_cnt == 0 && guard < 8000) begin tick(); guard++; end
      check("rnd_fd_timeout", fd2_cnt, 1);
      repeat (3) tick();
      wnd2 = 1'b0;
      tick();
      tick();
      check("rnd_idle", busy2, 1'b0);
      check("rnd_ack_count", ack2_cnt, NS2 - 1);
      check("rnd_fd_count", fd2_cnt, 1);
      check("rnd_col_count", obs2.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs2.size(); i++) begin
        check($sformatf("rnd_f%0d_c%0d_data", f, i), obs2[i].data, exp_q[i].data);
        check($sformatf("rnd_f%0d_c%0d_x", f, i), obs2[i].x, exp_q[i].x);
        check($sformatf("rnd_f%0d_c%0d_last", f, i), obs2[i].last, exp_q[i].last);
      end
      rnd2 = 1'b0;
      $display("dut2 frame %0d: %0d columns, %0d acks", f, obs2.size(), ack2_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
